pht_port_sched: RTL

- Owns the single address port of the 256-entry branch PHT RAM and schedules every access to it.
- Runs a post-reset clear sweep over all entries.
- Buffers branch-resolution updates from EX in a small FIFO and computes the new 2-bit saturating count.
- Arbitrates each cycle between fetch-side PHT reads and queued writes, with a starvation bound on writes.

---
 rtl/pht_port_sched_if.sv | 31 +++
 rtl/pht_port_sched.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pht_port_sched_if.sv
// Handshake and RAM-port bundle between the PHT port scheduler and its surroundings.
// The master modport is the environment side (EX, fetch and the RAM); the slave modport is the scheduler.
interface pht_port_sched_if;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [1:0]  upd_old_count;
  logic [31:0] upd_target;
  logic        upd_ready;
  logic        upd_flush;
  logic        rd_req;
  logic [7:0]  rd_index;
  logic        rd_grant;
  logic        ram_en;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [55:0] ram_wdata;
  logic        init_done;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_old_count, upd_target, upd_flush,
    output rd_req, rd_index,
    input  upd_ready, rd_grant, ram_en, ram_we, ram_addr, ram_wdata, init_done
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_old_count, upd_target, upd_flush,
    input  rd_req, rd_index,
    output upd_ready, rd_grant, ram_en, ram_we, ram_addr, ram_wdata, init_done
  );
endinterface

// File: rtl/pht_port_sched.sv
// Single-port PHT RAM scheduler: post-reset clear sweep, update FIFO with
// saturating-count computation, and read/write arbitration with a write starvation bound.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | clear sweep, one entry written per cycle, no reads or updates
// ST_RUN  | arbitrate fetch reads against queued update writes
module pht_port_sched #(
  parameter int         DEPTH        = 4,
  parameter int         STARVE_LIMIT = 3,
  parameter int         PHT_NUMS     = 256,
  parameter logic [1:0] INIT_COUNT   = 2'b11
) (
  input  logic              clk,
  input  logic              resetn,
  pht_port_sched_if.slave   bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = PW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [7:0]    LAST_IDX  = 8'(PHT_NUMS - 1);
  localparam logic [OW-1:0] OCC_FULL  = OW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MX = SW'(STARVE_LIMIT);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_q;
  logic [7:0]    ptr_q;
  logic          init_done_q;
  logic [PW-1:0] head_q, tail_q;
  logic [OW-1:0] occ_q, occ_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [7:0]    fifo_addr_q [DEPTH];
  logic [55:0]   fifo_data_q [DEPTH];

  logic is_run, fifo_empty, fifo_full, push, wr_sel;
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^bus.upd_pc[1:0];

  // Encoding: 00 WT, 01 ST, 10 WN, 11 SN.
  function automatic logic [1:0] next_count(input logic [1:0] old, input logic taken);
    logic [1:0] nc;
    unique case (old)
      2'b11:   nc = taken ? 2'b10 : 2'b11;
      2'b10:   nc = taken ? 2'b00 : 2'b11;
      2'b00:   nc = taken ? 2'b01 : 2'b10;
      default: nc = taken ? 2'b01 : 2'b00;
    endcase
    return nc;
  endfunction

  always_comb begin
    is_run        = (state_q == ST_RUN);
    fifo_empty    = (occ_q == '0);
    fifo_full     = (occ_q == OCC_FULL);
    bus.upd_ready = is_run && !fifo_full;
    push          = bus.upd_ready && bus.upd_valid && !bus.upd_flush;
    wr_sel        = is_run && !fifo_empty &&
                    (!bus.rd_req || fifo_full || (starve_q == STARVE_MX));
    bus.rd_grant  = is_run && !wr_sel && bus.rd_req;
    bus.init_done = init_done_q;

    // State is already INIT while resetn is low; qualify so the port idles during reset.
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (resetn) begin
      if (!is_run) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = ptr_q;
        bus.ram_wdata = {INIT_COUNT, 54'h0};
      end else if (wr_sel) begin
        bus.ram_en    = 1'b1;
        bus.ram_we    = 1'b1;
        bus.ram_addr  = fifo_addr_q[head_q];
        bus.ram_wdata = fifo_data_q[head_q];
      end else if (bus.rd_grant) begin
        bus.ram_en    = 1'b1;
        bus.ram_addr  = bus.rd_index;
      end
    end

    if (bus.upd_flush) occ_d = '0;
    else               occ_d = occ_q + OW'(push) - OW'(wr_sel);

    if (bus.upd_flush || fifo_empty || wr_sel) starve_d = '0;
    else if (bus.rd_grant && (starve_q != STARVE_MX)) starve_d = starve_q + SW'(1);
    else starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      ptr_q       <= '0;
      init_done_q <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      occ_q       <= '0;
      starve_q    <= '0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          ptr_q <= ptr_q + 8'd1;
          if (ptr_q == LAST_IDX) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        default: begin
          occ_q    <= occ_d;
          starve_q <= starve_d;
          if (bus.upd_flush) begin
            head_q <= '0;
            tail_q <= '0;
          end else begin
            if (push)   tail_q <= tail_q + PW'(1);
            if (wr_sel) head_q <= head_q + PW'(1);
          end
        end
      endcase
    end
  end

  // Entry storage needs no reset: occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= bus.upd_pc[9:2];
      fifo_data_q[tail_q] <= {next_count(bus.upd_old_count, bus.upd_taken),
                              bus.upd_pc[31:10], bus.upd_target};
    end
  end

endmodule
